// File: rtl/cache_repl_pkg.sv
// Shared types and tree pseudo-LRU helpers for the cache replacement logic.
package cache_repl_pkg;

   localparam int unsigned DEF_SET_SIZE    = 4;
   localparam int unsigned DEF_SET_NUM     = 128;
   localparam int unsigned DEF_WAY_WIDTH   = $clog2(DEF_SET_SIZE);
   localparam int unsigned DEF_INDEX_WIDTH = $clog2(DEF_SET_NUM);

   typedef logic [DEF_WAY_WIDTH-1:0]   way_t;
   typedef logic [DEF_INDEX_WIDTH-1:0] index_t;
   typedef logic [DEF_SET_SIZE-2:0]    plru_t;
   typedef logic [DEF_SET_SIZE-1:0]    valid_t;

   typedef struct packed {
      logic found;
      way_t way;
   } inv_pick_t;

   // Walk root to leaf along w's path, pointing every node away from w.
   // Node n has children 2n+1 (lower half) and 2n+2 (upper half).
   function automatic plru_t plru_touch(plru_t p, way_t w);
      plru_t       r;
      int unsigned node;
      r    = p;
      node = 0;
      for (int unsigned lvl = 0; lvl < DEF_WAY_WIDTH; lvl++) begin
         r[node] = ~w[DEF_WAY_WIDTH-1-lvl];
         node    = 2 * node + 1 + 32'(w[DEF_WAY_WIDTH-1-lvl]);
      end
      return r;
   endfunction

   // Follow the tree bits from the root; each bit read is the next way bit.
   function automatic way_t plru_victim(plru_t p);
      way_t        w;
      int unsigned node;
      w    = '0;
      node = 0;
      for (int unsigned lvl = 0; lvl < DEF_WAY_WIDTH; lvl++) begin
         w[DEF_WAY_WIDTH-1-lvl] = p[node];
         node                   = 2 * node + 1 + 32'(p[node]);
      end
      return w;
   endfunction

   // Lowest-index invalid way, if any.
   function automatic inv_pick_t first_invalid(valid_t v);
      inv_pick_t r;
      r.found = 1'b0;
      r.way   = '0;
      for (int unsigned i = 0; i < DEF_SET_SIZE; i++) begin
         if (!v[i] && !r.found) begin
            r.found = 1'b1;
            r.way   = way_t'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/cache_victim_sel_plru_set_update.sv
// Combinational next state of one set: access touch, then fill touch and
// valid set, then invalidate clear (PLRU untouched by invalidate).
module plru_set_update
   import cache_repl_pkg::*;
(
   input  logic   [DEF_SET_SIZE-1:0] valid_cur,
   input  logic   [DEF_SET_SIZE-2:0] plru_cur,
   input  logic                      acc_en,
   input  logic   [DEF_WAY_WIDTH-1:0] acc_way,
   input  logic                      fill_en,
   input  logic   [DEF_WAY_WIDTH-1:0] fill_way,
   input  logic                      inv_en,
   input  logic   [DEF_WAY_WIDTH-1:0] inv_way,
   output logic   [DEF_SET_SIZE-1:0] valid_nxt,
   output logic   [DEF_SET_SIZE-2:0] plru_nxt
);

   // Apply the three events in their fixed intra-cycle order.
   always_comb begin
      valid_nxt = valid_cur;
      plru_nxt  = plru_cur;
      if (acc_en) begin
         plru_nxt = plru_touch(plru_nxt, acc_way);
      end
      if (fill_en) begin
         plru_nxt            = plru_touch(plru_nxt, fill_way);
         valid_nxt[fill_way] = 1'b1;
      end
      if (inv_en) begin
         valid_nxt[inv_way] = 1'b0;
      end
   end

endmodule

// File: rtl/cache_victim_sel.sv
// Replacement-victim selector: per-set valid bits and tree PLRU, event
// absorption, and a registered victim response one cycle after each request.
module cache_victim_sel
   import cache_repl_pkg::*;
#(
   parameter int unsigned SET_SIZE    = DEF_SET_SIZE,
   parameter int unsigned SET_NUM     = DEF_SET_NUM,
   parameter int unsigned WAY_WIDTH   = $clog2(SET_SIZE),
   parameter int unsigned INDEX_WIDTH = $clog2(SET_NUM)
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   access_valid,
   input  logic [INDEX_WIDTH-1:0] access_index,
   input  logic [WAY_WIDTH-1:0]   access_way,
   input  logic                   fill_valid,
   input  logic [INDEX_WIDTH-1:0] fill_index,
   input  logic [WAY_WIDTH-1:0]   fill_way,
   input  logic                   inv_valid,
   input  logic [INDEX_WIDTH-1:0] inv_index,
   input  logic [WAY_WIDTH-1:0]   inv_way,
   input  logic                   victim_req,
   input  logic [INDEX_WIDTH-1:0] victim_index,
   output logic                   victim_valid,
   output logic [WAY_WIDTH-1:0]   victim_way,
   output logic                   victim_was_invalid
);

   valid_t    valid_q [SET_NUM];
   plru_t     plru_q  [SET_NUM];
   valid_t    valid_d [SET_NUM];
   plru_t     plru_d  [SET_NUM];

   valid_t    fwd_valid;
   plru_t     fwd_plru;
   inv_pick_t pick;
   way_t      resp_way;
   logic      resp_inv;

   // Write path: every set computes its next state from index-matched events.
   for (genvar s = 0; s < SET_NUM; s++) begin : g_set
      plru_set_update u_upd (
         .valid_cur (valid_q[s]),
         .plru_cur  (plru_q[s]),
         .acc_en    (access_valid && (access_index == index_t'(s))),
         .acc_way   (access_way),
         .fill_en   (fill_valid && (fill_index == index_t'(s))),
         .fill_way  (fill_way),
         .inv_en    (inv_valid && (inv_index == index_t'(s))),
         .inv_way   (inv_way),
         .valid_nxt (valid_d[s]),
         .plru_nxt  (plru_d[s])
      );
   end

   // Forwarding path: the requested set as it will look after this cycle.
   plru_set_update u_fwd (
      .valid_cur (valid_q[victim_index]),
      .plru_cur  (plru_q[victim_index]),
      .acc_en    (access_valid && (access_index == victim_index)),
      .acc_way   (access_way),
      .fill_en   (fill_valid && (fill_index == victim_index)),
      .fill_way  (fill_way),
      .inv_en    (inv_valid && (inv_index == victim_index)),
      .inv_way   (inv_way),
      .valid_nxt (fwd_valid),
      .plru_nxt  (fwd_plru)
   );

   // State arrays in flops; all sets cleared on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned s = 0; s < SET_NUM; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         for (int unsigned s = 0; s < SET_NUM; s++) begin
            valid_q[s] <= valid_d[s];
            plru_q[s]  <= plru_d[s];
         end
      end
   end

   // Victim choice: invalid way preferred over the PLRU walk.
   always_comb begin
      pick     = first_invalid(fwd_valid);
      resp_inv = pick.found;
      resp_way = pick.found ? pick.way : plru_victim(fwd_plru);
   end

   // Response register; way/was_invalid hold between requests.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         victim_valid       <= 1'b0;
         victim_way         <= '0;
         victim_was_invalid <= 1'b0;
      end else begin
         victim_valid <= victim_req;
         if (victim_req) begin
            victim_way         <= resp_way;
            victim_was_invalid <= resp_inv;
         end
      end
   end

endmodule

// File: doc/cache_victim_sel.md
# cache_victim_sel

Replacement-victim selector for the set-associative caches, and the consumer-side counterpart to the cache's way-choice generator. It keeps per-set valid bits and tree pseudo-LRU state, absorbs hit, refill and invalidate events from the cache pipeline, and returns a victim way for each miss request one cycle later. An invalid way is always preferred over evicting a valid line.

## Interface
- SET_SIZE, 4, ways per set; power of two, ≥2
- SET_NUM, 128, sets; power of two
- WAY_WIDTH, $clog2(SET_SIZE), way index width
- INDEX_WIDTH, $clog2(SET_NUM), set index width

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- access_valid  in  1  hit touch this cycle
- access_index  in  INDEX_WIDTH  set of hit
- access_way  in  WAY_WIDTH  way hit
- fill_valid  in  1  refill commit this cycle; marks way valid and touches it
- fill_index  in  INDEX_WIDTH
- fill_way  in  WAY_WIDTH
- inv_valid  in  1  invalidate one line (cacop/coherence)
- inv_index  in  INDEX_WIDTH
- inv_way  in  WAY_WIDTH
- victim_req  in  1  miss needs a victim
- victim_index  in  INDEX_WIDTH
- victim_valid  out  1  response strobe, one cycle after victim_req
- victim_way  out  WAY_WIDTH  chosen way
- victim_was_invalid  out  1  chosen way was invalid (no writeback needed)

## Operation
- State per set: valid[SET_SIZE], plru[SET_SIZE-1] tree bits. Node 0 is root; children of node n are 2n+1, 2n+2.
- Tree walk: bit 0 → lower half, 1 → upper half.
- Touch way w: every node on w's path is set to point away from w.
- Victim: lowest-index invalid way if any (victim_was_invalid=1), else the PLRU walk result (victim_was_invalid=0).
- Victim selection does not modify state. The cache signals the refill via fill_valid.
- Same-cycle events, applied in order within a cycle:
  - access touch, then fill touch + valid set, then inv valid clear.
  - Fill and inv on the same way: line ends invalid.
  - Touches to different indices are independent.
- Invalidate does not change PLRU bits.
- Forwarding: a victim_req in cycle N is evaluated on the set's state after all cycle-N updates, including updates to the same index.
- victim_req accepted every cycle; no backpressure; fully pipelined.
- Out-of-range way inputs cannot occur (power-of-two SET_SIZE).

## Timing
- Reset (async assert, sync-visible deassert):
  - all valid=0, all plru=0
  - victim_valid=0, victim_way=0, victim_was_invalid=0
- Reset asserted mid-operation: any pending response is dropped immediately; victim_valid low while reset is high.
- Latency: victim_req at edge N → victim_valid=1 for exactly the cycle after edge N. Outputs are registered.
- Update latency: events sampled at edge N are visible to a victim_req sampled at edge N, through forwarding.
- victim_way and victim_was_invalid hold their last value when victim_valid=0.
- State storage is flops. No RAM read latency is permitted.

## Structure
- Package cache_repl_pkg holds:
  - way_t, index_t
  - plru_t (logic [SET_SIZE-2:0])
  - function plru_touch(plru_t, way_t)
  - function plru_victim(plru_t)
  - function first_invalid(valid) returning found flag + way
- Sub-module plru_set_update: combinational next-state for one set, taking current valid/plru plus the three event enables. It is reused for the write path and for the victim forwarding path.
- Top level holds the state arrays, the update decode per index, and the response register.

## Test plan
1. Reset, then victim_req index 5 → next cycle victim_valid=1, way 0, was_invalid=1.
2. Fill index 5 ways 0,1,2,3 on successive cycles, then req index 5 → way 0, was_invalid=0 (plru=3'b000 after the sequence).
3. Continue from 2: access index 5 way 0, then req → way 2 (root=1, node2=0).
4. Continue from 3: inv index 5 way 3, then req → way 3, was_invalid=1. PLRU bits unchanged.
5. After reset: fill index 7 way 0 and victim_req index 7 in the same cycle → way 1, was_invalid=1 (forwarding). Fill and inv on index 7 way 1 in the same cycle → way 1 stays invalid.
6. Assert reset asynchronously while victim_valid=1 → victim_valid falls before the next edge. A subsequent req on any index returns way 0, was_invalid=1.
